// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, one bit per clock.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational product instead.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wa_out,
    output logic            we_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          wa_q, wa_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic [2:0]          f3_q, f3_d;

    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_w(input logic n, input logic [2*XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    // Operand decode at acceptance
    logic            accept, is_div_in, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            short_path;
    logic [XLEN-1:0] short_res;

    assign accept    = start && (state_q != CALC);
    assign is_div_in = funct3[2];
    assign a_signed  = is_div_in ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign b_signed  = is_div_in ? ~funct3[0] : ~funct3[1];
    assign a_neg     = a_signed & op_a[XLEN-1];
    assign b_neg     = b_signed & op_b[XLEN-1];
    assign a_mag     = neg_if(a_neg, op_a);
    assign b_mag     = neg_if(b_neg, op_b);

    assign div_zero    = is_div_in && (op_b == '0);
    assign div_ovf     = is_div_in && ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign special     = div_zero | div_ovf;
    assign special_res = div_zero ? (funct3[1] ? op_a : '1)
                                  : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fa, fb, fprod;
    assign fa         = {{XLEN{a_neg}}, op_a};
    assign fb         = {{XLEN{b_neg}}, op_b};
    assign fprod      = fa * fb;
    assign short_path = special | ~is_div_in;
    assign short_res  = is_div_in ? special_res
                      : (funct3[1:0] == 2'b00 ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN]);
`else
    assign short_path = special;
    assign short_res  = special_res;
`endif

    // One iteration: acc holds {hi, lo} = {partial product, multiplier} or {remainder, quotient}
    logic [XLEN:0]     msum, rsh;
    logic [XLEN-1:0]   rdiff;
    logic              ge;
    logic [2*XLEN-1:0] mul_next, div_next, step_acc, prod;
    logic [XLEN-1:0]   quo_f, rem_f, final_res;

    assign msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {msum, acc_q[XLEN-1:1]};
    assign rsh      = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign ge       = rsh >= {1'b0, opnd_q};
    assign rdiff    = rsh[XLEN-1:0] - opnd_q;
    assign div_next = ge ? {rdiff, acc_q[XLEN-2:0], 1'b1} : {rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    assign step_acc = f3_q[2] ? div_next : mul_next;

    assign prod      = neg_if_w(neg_q, step_acc);
    assign quo_f     = neg_if(neg_q, step_acc[XLEN-1:0]);
    assign rem_f     = neg_if(rneg_q, step_acc[2*XLEN-1:XLEN]);
    assign final_res = f3_q[2] ? (f3_q[1] ? rem_f : quo_f)
                     : (f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? (short_path ? DONE : CALC) : IDLE;
            CALC:       if (cnt_q == '0) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == CALC);
        done   = (state_q == DONE);
        we_out = done && (wa_q != '0);
    end

    assign result = result_q;
    assign wa_out = wa_q;

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        f3_d     = f3_q;
        wa_d     = wa_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        if (accept) begin
            f3_d   = funct3;
            wa_d   = rd_in;
            cnt_d  = CNT_W'(XLEN-1);
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            acc_d  = {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
            opnd_d = is_div_in ? b_mag : a_mag;
            if (short_path) result_d = short_res;
        end else if (state_q == CALC) begin
            acc_d = step_acc;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) result_d = final_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            result_q <= '0;
            wa_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            result_q <= result_d;
            wa_q     <= wa_d;
        end
    end

    // Datapath registers carry no reset; they are always loaded on acceptance before use
    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        opnd_q <= opnd_d;
        neg_q  <= neg_d;
        rneg_q <= rneg_d;
        f3_q   <= f3_d;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized traffic vs a behavioural model.
module tb_muldiv_unit;

    logic        clk, rst, start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, we_out;
    logic [31:0] result;
    logic [4:0]  wa_out;

    int n_checks = 0;
    int n_err    = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result),
        .wa_out(wa_out), .we_out(we_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ub;
        longint unsigned ua64, ub64;
        logic [63:0]     p;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        if (f[2] && b == 0) return 1;
        if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Model: m_cnt = cycles until result delivery (1 = the done cycle)
    int          m_cnt;
    logic [31:0] m_res, m_pend;
    logic [4:0]  m_wa;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt <= 0; m_res <= '0; m_pend <= '0; m_wa <= '0;
        end else if (start && m_cnt <= 1) begin
            m_cnt  <= lat_of(funct3, op_a, op_b);
            m_pend <= ref_res(funct3, op_a, op_b);
            m_wa   <= rd_in;
            if (lat_of(funct3, op_a, op_b) == 1) m_res <= ref_res(funct3, op_a, op_b);
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_res <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_we", we_out, 0);
            chk("rst_result", result, 0);
            chk("rst_wa", wa_out, 0);
        end else begin
            chk("busy", busy, m_cnt > 1);
            chk("done", done, m_cnt == 1);
            chk("we_out", we_out, (m_cnt == 1) && (m_wa != 0));
            chk("wa_out", wa_out, m_wa);
            chk("result", result, m_res);
        end
    end

    task automatic issue(input bit wait_edge, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        if (wait_edge) @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp_res, input int exp_lat,
                             input logic [4:0] rd);
        int k, bcnt;
        bit seen;
        @(negedge clk);
        start = 1'b0;
        k = 1; bcnt = 0; seen = 0;
        while (!seen && k <= 40) begin
            if (done) seen = 1;
            else begin
                if (busy) bcnt++;
                @(negedge clk);
                k++;
            end
        end
        chk({name, "_seen"}, seen, 1);
        chk({name, "_lat"}, k, exp_lat);
        chk({name, "_busycyc"}, bcnt, exp_lat - 1);
        chk({name, "_res"}, result, exp_res);
        chk({name, "_wa"}, wa_out, rd);
        chk({name, "_we"}, we_out, rd != 0);
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k, dcnt;
        bit seen;
        rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        rst = 1'b1;

        chk("model_mulh", ref_res(3'd1, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
        chk("model_rem", ref_res(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

        issue(1, 3'd0, 32'd7, 32'd6, 5'd5);                wait_done("mul", 32'd42, lat_of(3'd0, 7, 6), 5'd5);
        issue(1, 3'd1, 32'hFFFFFFFF, 32'd2, 5'd3);         wait_done("mulh", 32'hFFFFFFFF, lat_of(3'd1, 0, 2), 5'd3);
        issue(1, 3'd3, 32'hFFFFFFFF, 32'd2, 5'd4);         wait_done("mulhu", 32'h1, lat_of(3'd3, 0, 2), 5'd4);
        issue(1, 3'd4, 32'hFFFFFFF9, 32'd2, 5'd6);         wait_done("div", 32'hFFFFFFFD, 33, 5'd6);
        issue(1, 3'd6, 32'hFFFFFFF9, 32'd2, 5'd7);         wait_done("rem", 32'hFFFFFFFF, 33, 5'd7);
        issue(1, 3'd5, 32'd20, 32'd0, 5'd8);               wait_done("divu_z", 32'hFFFFFFFF, 1, 5'd8);
        issue(1, 3'd6, 32'd20, 32'd0, 5'd9);               wait_done("rem_z", 32'd20, 1, 5'd9);
        issue(1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10); wait_done("div_ovf", 32'h80000000, 1, 5'd10);
        issue(1, 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11); wait_done("rem_ovf", 32'h0, 1, 5'd11);
        issue(1, 3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd12); wait_done("mulhsu", 32'h80000000, lat_of(3'd2, 0, 1), 5'd12);
        issue(1, 3'd0, 32'd9, 32'd9, 5'd0);                wait_done("mul_x0", 32'd81, lat_of(3'd0, 9, 9), 5'd0);

        // Back-to-back: new start issued in the DONE cycle of the previous op
        issue(1, 3'd5, 32'd100, 32'd7, 5'd13);             wait_done("b2b_a", 32'd14, 33, 5'd13);
        issue(0, 3'd7, 32'd100, 32'd7, 5'd14);             wait_done("b2b_b", 32'd2, 33, 5'd14);

        // Start during CALC must be ignored
        issue(1, 3'd5, 32'd15, 32'd5, 5'd7);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; funct3 = 3'd6; op_a = 32'd100; op_b = 32'd3; rd_in = 5'd9;
        @(negedge clk); start = 1'b0;
        k = 5; seen = 0;
        while (!seen && k <= 40) begin
            if (done) seen = 1;
            else begin @(negedge clk); k++; end
        end
        chk("ign_seen", seen, 1);
        chk("ign_lat", k, 33);
        chk("ign_res", result, 32'd3);
        chk("ign_wa", wa_out, 5'd7);

        // Asynchronous reset in the middle of a divide
        issue(1, 3'd5, 32'd1000, 32'd3, 5'd15);
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_we", we_out, 0);
        chk("midrst_result", result, 0);
        chk("midrst_wa", wa_out, 0);
        @(negedge clk);
        rst = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_nodone", dcnt, 0);

        // Randomized traffic, including starts while busy and varying operands
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 5) == 0);
            funct3 = 3'($urandom_range(0, 7));
            op_a   = rval();
            op_b   = rval();
            rd_in  = 5'($urandom_range(0, 31));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits directly downstream of the register file.
- Consumes rd1/rd2 as operands and returns a 32-bit result plus the destination register index, which drive the register file write port (wd/wa/we) through the writeback mux.
- Stalls the single-cycle core via busy while an operation is in flight.
- Radix-2 iterative datapath: one bit per clock.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled on the rising edge.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  32  rs1 value (register file rd1).
- op_b  input  32  rs2 value (register file rd2).
- rd_in  input  5  destination register index.
- busy  output  1  high while in CALC; core must hold its PC.
- done  output  1  one-cycle pulse; result is valid.
- result  output  32  result value; held until the next accepted start.
- wa_out  output  5  latched rd_in; drives register file wa.
- we_out  output  1  equals done AND (wa_out != 0).

Behaviour:
- Reset: the reset condition is rst low, asynchronous and active-low; clock is clk.
  - State goes to IDLE.
  - busy=0, done=0, we_out=0, result=0, wa_out=0, counter=0.
  - Reset asserted mid-operation aborts the operation with no done pulse and no write.
- States: IDLE, CALC, DONE.
- Accepting a start:
  - start is accepted on the edge only when the state is IDLE or DONE.
  - On acceptance, latch funct3 and rd_in, take the absolute values of the signed operands, and record the result sign.
  - start while in CALC is ignored; the latched operands and funct3 must not change.
- Normal operation: accepted start → CALC with counter=31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, producing the quotient and remainder.
  - Each CALC edge decrements the counter.
  - On the edge where counter==0, apply the sign fix-up, load result, and go to DONE.
- Latency:
  - busy is high for exactly 32 cycles.
  - done is high for exactly one cycle, 33 cycles after the accepting edge.
- DONE → IDLE on the next edge unless start is high; a start in DONE is accepted back-to-back.
- Result selection:
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
  - MULHSU treats op_a as signed and op_b as unsigned.
- Signed divide/remainder rules:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases skip CALC and go directly to DONE, so done arrives 1 cycle after the accepting edge and busy never rises:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Writeback:
  - we_out is never asserted for wa_out==0.
  - result is still updated in that case.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops use a combinational 33x33 signed product.
  - They go IDLE→DONE directly, so done arrives 1 cycle after acceptance with no busy.
  - Divide ops are unchanged.
- Undefined: multiply is iterative, 32 cycles, as specified above.

Test Plan:
- MUL with op_a=7, op_b=6, rd_in=5:
  - busy is high for 32 cycles.
  - done is high 33 cycles after start, with result=42, wa_out=5, we_out=1.
- MULH with op_a=0xFFFFFFFF (−1), op_b=2 → result 0xFFFFFFFF.
- MULHU with the same operands (0xFFFFFFFF, 2) → result 0x00000001.
- DIV with op_a=−7, op_b=2 → quotient 0xFFFFFFFD (−3).
- REM with op_a=−7, op_b=2 → result 0xFFFFFFFF (−1).
- DIVU with op_a=20, op_b=0 → result 0xFFFFFFFF.
- REM with op_a=20, op_b=0 → result 20.
  - In both divide-by-zero cases, done arrives 1 cycle after start and busy is never high.
- DIV with op_a=0x80000000, op_b=0xFFFFFFFF → result 0x80000000.
- REM with the same operands → result 0, 1-cycle latency.
- Start a DIVU, drop rst low at CALC cycle 10:
  - Outputs clear immediately.
  - No done pulse.
- A new start during CALC is ignored and the original result is produced.
- A start in the DONE cycle is accepted back-to-back.
- MUL with rd_in=0 → done=1 and we_out=0.
